// File: rtl/dff_pipe_sync_rst_set_pkg.sv
// Shared helpers for the register pipeline: only the ceiling-log2 used to
// size the occupancy counter lives here.
package dff_pipe_sync_rst_set_pkg;

    // Smallest r with 2**r >= value; evaluated at elaboration for port widths.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dff_sync_reset_set_en.sv
// One WIDTH-bit pipeline stage: synchronous reset beats synchronous set,
// which beats the load enable; otherwise the stage holds its value.
module dff_sync_reset_set_en
    import dff_pipe_sync_rst_set_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] SET_VAL   = {WIDTH{1'b1}}
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             SET,
    input  logic             EN,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (SET) begin
            data_d = SET_VAL;
        end else if (EN) begin
            data_d = D;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            data_q <= RESET_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign Q = data_q;

endmodule

// File: rtl/dff_pipe_sync_rst_set.sv
// Parametrised delay line of DEPTH register stages with per-stage valid flags
// and a registered count of how many stages currently hold valid data.
module dff_pipe_sync_rst_set
    import dff_pipe_sync_rst_set_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] SET_VAL   = {WIDTH{1'b1}}
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         SET,
    input  logic                         EN,
    input  logic [WIDTH-1:0]             D,
    input  logic                         D_VALID,
    output logic [WIDTH-1:0]             Q,
    output logic                         Q_VALID,
    output logic [clog2(DEPTH+1)-1:0]    OCC
);

    localparam int OCC_W = clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    logic [DEPTH:0][WIDTH-1:0] dataChain;
    logic [DEPTH-1:0]          valid_q;
    logic [DEPTH-1:0]          valid_d;
    logic [OCC_W-1:0]          occ_q;
    logic [OCC_W-1:0]          occ_d;

    assign dataChain[0] = D;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        dff_sync_reset_set_en #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL),
            .SET_VAL   (SET_VAL)
        ) u_stage (
            .CLK   (CLK),
            .RESET (RESET),
            .SET   (SET),
            .EN    (EN),
            .D     (dataChain[i]),
            .Q     (dataChain[i+1])
        );
    end

    always_comb begin
        valid_d = valid_q;
        if (SET) begin
            valid_d = {DEPTH{1'b1}};
        end else if (EN) begin
            valid_d[0] = D_VALID;
            for (int i = 1; i < DEPTH; i++) begin
                valid_d[i] = valid_q[i-1];
            end
        end
    end

    // The count tracks entries and exits instead of summing flags, so it
    // only moves when exactly one valid item enters or leaves on a shift.
    always_comb begin
        occ_d = occ_q;
        if (SET) begin
            occ_d = OCC_FULL;
        end else if (EN) begin
            case ({D_VALID, valid_q[DEPTH-1]})
                2'b10: if (occ_q != OCC_FULL) occ_d = occ_q + 1'b1;
                2'b01: if (occ_q != '0)       occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
        end
    end

    assign Q       = dataChain[DEPTH];
    assign Q_VALID = valid_q[DEPTH-1];
    assign OCC     = occ_q;

endmodule

// File: tb/tb_dff_pipe_sync_rst_set.sv
// Scoreboard bench for a 3-deep, 8-bit pipeline: directed vectors with
// hand-worked expectations, then a random run against a shift-queue model.
module tb_dff_pipe_sync_rst_set;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;

    logic             CLK;
    logic             RESET;
    logic             SET;
    logic             EN;
    logic [WIDTH-1:0] D;
    logic             D_VALID;
    logic [WIDTH-1:0] Q;
    logic             Q_VALID;
    logic [1:0]       OCC;

    typedef struct packed {
        logic [7:0] q;
        logic       qv;
        logic [1:0] occ;
    } exp_t;

    exp_t expQueue[$];
    int   checks = 0;
    int   errors = 0;

    logic [7:0] mData  [DEPTH];
    logic       mValid [DEPTH];

    dff_pipe_sync_rst_set #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (8'h00),
        .SET_VAL   (8'hFF)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .SET     (SET),
        .EN      (EN),
        .D       (D),
        .D_VALID (D_VALID),
        .Q       (Q),
        .Q_VALID (Q_VALID),
        .OCC     (OCC)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs and queue what the outputs must be after the edge.
    task automatic applyStimulus(input logic rst, input logic set, input logic en,
                                 input logic [7:0] d, input logic dv,
                                 input logic [7:0] eq, input logic ev, input logic [1:0] eo);
        exp_t e;
        @(negedge CLK);
        RESET   = rst;
        SET     = set;
        EN      = en;
        D       = d;
        D_VALID = dv;
        @(posedge CLK);
        e.q   = eq;
        e.qv  = ev;
        e.occ = eo;
        expQueue.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (expQueue.size() > 0) begin
                e = expQueue.pop_front();
                checkOutput("Q", int'(Q), int'(e.q));
                checkOutput("Q_VALID", int'(Q_VALID), int'(e.qv));
                checkOutput("OCC", int'(OCC), int'(e.occ));
                checks++;
                if (int'(OCC) > DEPTH) begin
                    errors++;
                    $display("[TB] FAIL OCC_BOUND: got %0d limit %0d", OCC, DEPTH);
                end
            end
        end
    end

    initial begin : stimulus
        int         popCount;
        int         wait_cycles;
        logic       rst;
        logic       set;
        logic       en;
        logic       dv;
        logic [7:0] d;

        RESET = 1'b0; SET = 1'b0; EN = 1'b0; D = '0; D_VALID = 1'b0;

        // Directed: reset, fill, stall, drain, set, drain to empty, reset+set.
        //            rst  set  en    D      dv    Q      Qv    OCC
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hA1, 1'b1, 8'h00, 1'b0, 2'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hB2, 1'b1, 8'h00, 1'b0, 2'd2);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hC3, 1'b1, 8'hA1, 1'b1, 2'd3);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hD4, 1'b1, 8'hB2, 1'b1, 2'd3);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'hEE, 1'b1, 8'hB2, 1'b1, 2'd3);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'hEE, 1'b0, 8'hB2, 1'b1, 2'd3);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hE5, 1'b0, 8'hC3, 1'b1, 2'd2);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 8'hFF, 1'b1, 2'd3);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 8'hFF, 1'b1, 2'd2);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 8'hFF, 1'b1, 2'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 8'h22, 1'b0, 2'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 8'h33, 1'b0, 2'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 8'h44, 1'b0, 2'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h77, 1'b1, 8'h00, 1'b0, 2'd0);

        // Random run; the first cycle forces RESET so the model starts in sync.
        for (int cyc = 0; cyc < 1000; cyc++) begin
            rst = (cyc == 0) || ($urandom_range(0, 99) < 3);
            set = ($urandom_range(0, 99) < 4);
            en  = ($urandom_range(0, 99) < 70);
            dv  = 1'($urandom_range(0, 1));
            d   = 8'($urandom_range(0, 255));
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mData[i]  = 8'h00;
                    mValid[i] = 1'b0;
                end
            end else if (set) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mData[i]  = 8'hFF;
                    mValid[i] = 1'b1;
                end
            end else if (en) begin
                for (int i = DEPTH - 1; i > 0; i--) begin
                    mData[i]  = mData[i-1];
                    mValid[i] = mValid[i-1];
                end
                mData[0]  = d;
                mValid[0] = dv;
            end
            popCount = 0;
            for (int i = 0; i < DEPTH; i++) begin
                popCount += int'(mValid[i]);
            end
            applyStimulus(rst, set, en, d, dv, mData[DEPTH-1], mValid[DEPTH-1], 2'(popCount));
        end

        wait_cycles = 0;
        while (expQueue.size() > 0 && wait_cycles < 20) begin
            @(negedge CLK);
            wait_cycles++;
        end
        if (expQueue.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL DRAIN: got %0d pending expected 0", expQueue.size());
        end
        @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
